// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-requester RAM port arbiter.
// Optional burst lock is enabled by defining RAM_ARB_LOCK_EN.
package ram_arb_pkg;

   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 8;
   localparam int NUM_REQ    = 2;

   typedef logic req_id_t;

   localparam req_id_t REQ0 = 1'b0;
   localparam req_id_t REQ1 = 1'b1;

   // The requester that did not win last time gets first pick on contention.
   function automatic req_id_t rr_pick(input logic [NUM_REQ-1:0] req_vec,
                                       input req_id_t last_gnt);
      req_id_t pick;
      pick = REQ0;
      if (req_vec[REQ0] && req_vec[REQ1])
         pick = ~last_gnt;
      else if (req_vec[REQ1])
         pick = REQ1;
      return pick;
   endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a priority pointer and, when
// RAM_ARB_LOCK_EN is defined, burst-lock hold for the current winner.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_vec,
`ifdef RAM_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]   lock_vec,
`endif
   output logic [NUM_REQ-1:0]   gnt_vec,
   output logic                 any_gnt,
   output req_id_t              win_id
);

   req_id_t last_gnt_reg;
   req_id_t last_gnt_next;
`ifdef RAM_ARB_LOCK_EN
   logic    hold_reg;
   logic    hold_next;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt_reg <= REQ1;
`ifdef RAM_ARB_LOCK_EN
         hold_reg     <= 1'b0;
`endif
      end else begin
         last_gnt_reg <= last_gnt_next;
`ifdef RAM_ARB_LOCK_EN
         hold_reg     <= hold_next;
`endif
      end
   end

   always_comb begin
      any_gnt = |req_vec;
      win_id  = rr_pick(req_vec, last_gnt_reg);
`ifdef RAM_ARB_LOCK_EN
      // A locked owner keeps the grant for as long as it holds req and lock.
      if (hold_reg && req_vec[last_gnt_reg] && lock_vec[last_gnt_reg])
         win_id = last_gnt_reg;
      hold_next = any_gnt && lock_vec[win_id];
`endif
      last_gnt_next = any_gnt ? win_id : last_gnt_reg;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
         assign gnt_vec[gi] = any_gnt && (win_id == req_id_t'(gi));
      end
   endgenerate

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between two requesters: grant, pin mux and
// read-return routing. Burst lock ports exist only with RAM_ARB_LOCK_EN.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
`ifdef RAM_ARB_LOCK_EN
   input  logic              lock0,
   input  logic              lock1,
`endif
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] ram_data,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [ADDR_W-1:0] ram_rd_addr,
   output logic              ram_wr_en,
   input  logic [DATA_W-1:0] ram_q
);

   logic [NUM_REQ-1:0] req_vec;
   logic [NUM_REQ-1:0] gnt_vec;
   logic               any_gnt;
   req_id_t            win_id;

   logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
   logic [NUM_REQ-1:0] we_vec;
   logic [NUM_REQ-1:0] rvalid_vec;
   logic [DATA_W-1:0]  rdata_arr [NUM_REQ];

   assign req_vec      = {req1, req0};
   assign we_vec       = {we1, we0};
   assign addr_arr[0]  = addr0;
   assign addr_arr[1]  = addr1;
   assign wdata_arr[0] = wdata0;
   assign wdata_arr[1] = wdata1;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_vec (req_vec),
`ifdef RAM_ARB_LOCK_EN
      .lock_vec({lock1, lock0}),
`endif
      .gnt_vec (gnt_vec),
      .any_gnt (any_gnt),
      .win_id  (win_id)
   );

   assign gnt0 = gnt_vec[0];
   assign gnt1 = gnt_vec[1];

   // Pins are forced to zero when idle so the RAM sees a quiet bus.
   always_comb begin
      ram_wr_addr = '0;
      ram_rd_addr = '0;
      ram_data    = '0;
      ram_wr_en   = 1'b0;
      if (any_gnt) begin
         ram_wr_addr = addr_arr[win_id];
         ram_rd_addr = addr_arr[win_id];
         ram_data    = wdata_arr[win_id];
         ram_wr_en   = we_vec[win_id];
      end
   end

   logic    pend_valid_reg;
   logic    pend_valid_next;
   req_id_t pend_id_reg;
   req_id_t pend_id_next;

   assign pend_valid_next = any_gnt && !we_vec[win_id];
   assign pend_id_next    = win_id;

   // Tracks which requester owns the RAM output presented after this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid_reg <= 1'b0;
         pend_id_reg    <= REQ0;
      end else begin
         pend_valid_reg <= pend_valid_next;
         pend_id_reg    <= pend_id_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_ret
         logic              rvalid_reg;
         logic [DATA_W-1:0] rdata_reg;
         logic              hit_next;

         assign hit_next = pend_valid_reg && (pend_id_reg == req_id_t'(gi));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rvalid_reg <= 1'b0;
               rdata_reg  <= '0;
            end else begin
               rvalid_reg <= hit_next;
               if (hit_next)
                  rdata_reg <= ram_q;
            end
         end

         assign rvalid_vec[gi] = rvalid_reg;
         assign rdata_arr[gi]  = rdata_reg;
      end
   endgenerate

   assign rvalid0 = rvalid_vec[0];
   assign rvalid1 = rvalid_vec[1];
   assign rdata0  = rdata_arr[0];
   assign rdata1  = rdata_arr[1];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed plus randomized bench for ram_port_arbiter against a cycle-level
// transaction model; lock scenario is exercised when RAM_ARB_LOCK_EN is set.
module tb_ram_port_arbiter;

   localparam int AW = 6;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          lock0 = 0, lock1 = 0;
   logic          gnt0, gnt1, rvalid0, rvalid1, ram_wr_en;
   logic [DW-1:0] rdata0, rdata1, ram_data, ram_q;
   logic [AW-1:0] ram_wr_addr, ram_rd_addr;

   always #5 clk = ~clk;

   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef RAM_ARB_LOCK_EN
      .lock0(lock0), .lock1(lock1),
`endif
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .ram_data(ram_data),
      .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
      .ram_wr_en(ram_wr_en), .ram_q(ram_q)
   );

   // Behavioural RAM: write port plus registered read port.
   logic [DW-1:0] ram_mem [64];
   always @(posedge clk) begin
      if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_data;
      ram_q <= ram_mem[ram_rd_addr];
   end

   // Reference model state.
   typedef struct { int id; logic [DW-1:0] d; int due; } rd_t;
   rd_t           rd_q [$];
   logic [DW-1:0] m_mem [64];
   logic [DW-1:0] m_rdata [2];
   int            m_last, m_owner, cyc, last_win;
   int            total = 0, bad = 0;

   logic          s_req [2], s_we [2], s_lock [2];
   logic [AW-1:0] s_addr [2];
   logic [DW-1:0] s_data [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      rd_q.delete();
      m_last = 1; m_owner = -1;
      m_rdata[0] = '0; m_rdata[1] = '0;
   endtask

   task automatic clear_stim();
      for (int i = 0; i < 2; i++) begin
         s_req[i] = 0; s_we[i] = 0; s_lock[i] = 0; s_addr[i] = '0; s_data[i] = '0;
      end
   endtask

   function automatic int exp_win();
      if (m_owner >= 0 && s_req[m_owner] && s_lock[m_owner]) return m_owner;
      if (s_req[0] && s_req[1]) return (m_last == 1) ? 0 : 1;
      if (s_req[0]) return 0;
      if (s_req[1]) return 1;
      return -1;
   endfunction

   // One bus cycle: drive, check outputs against the model, advance model.
   task automatic step();
      int w;
      logic ev [2];
      @(posedge clk); #1;
      req0 = s_req[0]; we0 = s_we[0]; addr0 = s_addr[0]; wdata0 = s_data[0]; lock0 = s_lock[0];
      req1 = s_req[1]; we1 = s_we[1]; addr1 = s_addr[1]; wdata1 = s_data[1]; lock1 = s_lock[1];
      #3;
      w = exp_win();
      ev[0] = 0; ev[1] = 0;
      while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
         ev[rd_q[0].id] = 1;
         m_rdata[rd_q[0].id] = rd_q[0].d;
         void'(rd_q.pop_front());
      end
      chk("gnt0", gnt0, w == 0);
      chk("gnt1", gnt1, w == 1);
      chk("rvalid0", rvalid0, ev[0]);
      chk("rvalid1", rvalid1, ev[1]);
      chk("rdata0", rdata0, m_rdata[0]);
      chk("rdata1", rdata1, m_rdata[1]);
      chk("ram_wr_en", ram_wr_en, (w >= 0) ? s_we[w] : 1'b0);
      chk("ram_wr_addr", ram_wr_addr, (w >= 0) ? s_addr[w] : '0);
      chk("ram_rd_addr", ram_rd_addr, (w >= 0) ? s_addr[w] : '0);
      chk("ram_data", ram_data, (w >= 0) ? s_data[w] : '0);
      $display("cyc=%0d req=%b%b win=%0d gnt=%b%b rv=%b%b rd0=%0d rd1=%0d",
               cyc, s_req[1], s_req[0], w, gnt1, gnt0, rvalid1, rvalid0, rdata0, rdata1);
      if (w >= 0) begin
         if (s_we[w]) m_mem[s_addr[w]] = s_data[w];
         else rd_q.push_back('{id: w, d: m_mem[s_addr[w]], due: cyc + 2});
         m_last  = w;
         m_owner = s_lock[w] ? w : -1;
      end else begin
         m_owner = -1;
      end
      last_win = w;
      cyc++;
   endtask

   task automatic idle(input int n);
      clear_stim();
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic one(input int id, input logic we, input int a, input int d);
      clear_stim();
      s_req[id] = 1; s_we[id] = we; s_addr[id] = AW'(a); s_data[id] = DW'(d);
      step();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin ram_mem[i] = '0; m_mem[i] = '0; end
      cyc = 0; last_win = -1;
      model_reset(); clear_stim();
      #12;
      chk("reset_gnt", {gnt1, gnt0}, 2'b00);
      chk("reset_rvalid", {rvalid1, rvalid0}, 2'b00);
      chk("reset_rdata", {rdata1, rdata0}, 16'h0);
      chk("reset_pins", {ram_wr_en, ram_wr_addr, ram_data}, '0);
      @(posedge clk); #1 rst_n = 1;

      // Contention straight out of reset: R0, R1, R0, R1.
      clear_stim();
      s_req[0] = 1; s_req[1] = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("contention_order", last_win, i % 2);
      end

      // R0 writes then reads back on consecutive cycles.
      one(0, 1, 0, 55); one(0, 1, 1, 100); one(0, 1, 2, 200);
      one(0, 0, 0, 0);  one(0, 0, 1, 0);   one(0, 0, 2, 0);
      idle(2);
      chk("r0_readback_last", rdata0, 200);

      // Read routing: R0 reads 1, R1 reads 2 in adjacent cycles.
      one(0, 0, 1, 0); one(1, 0, 2, 0);
      idle(2);
      chk("route_rdata0", rdata0, 100);
      chk("route_rdata1", rdata1, 200);

      // Idle cycles keep priority after an R1 grant.
      one(1, 0, 3, 0);
      idle(3);
      clear_stim(); s_req[0] = 1; s_req[1] = 1;
      step();
      chk("idle_keeps_prio", last_win, 0);

      // Reset in the cycle after a read grant drops the read.
      one(1, 0, 2, 0);
      @(posedge clk); #1 rst_n = 0;
      clear_stim(); req0 = 0; req1 = 0;
      #3;
      chk("rst_mid_rvalid", {rvalid1, rvalid0}, 2'b00);
      chk("rst_mid_rdata", {rdata1, rdata0}, 16'h0);
      model_reset();
      @(posedge clk); #1 rst_n = 1;
      idle(3);
      clear_stim(); s_req[0] = 1; s_req[1] = 1;
      step();
      chk("rst_prio_r0", last_win, 0);
      idle(2);

`ifdef RAM_ARB_LOCK_EN
      // R1 holds lock for three cycles against a waiting R0.
      one(0, 1, 5, 7);
      clear_stim(); s_req[0] = 1; s_req[1] = 1; s_lock[1] = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("lock_hold_r1", last_win, 1);
      end
      s_lock[1] = 0;
      step();
      chk("lock_release_r0", last_win, 0);
      idle(2);
`endif

      // Randomized traffic with requests held until granted.
      clear_stim();
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (!s_req[i] && ($urandom_range(0, 9) < 7)) begin
               s_req[i]  = 1;
               s_we[i]   = $urandom_range(0, 1);
               s_addr[i] = AW'($urandom_range(0, 7));
               s_data[i] = DW'($urandom);
            end
         end
         step();
         if (last_win >= 0) s_req[last_win] = 0;
      end
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one 64x8 single-port RAM (write port plus read port, common clk) between two requesters, R0 and R1.
- Grants at most one access per cycle using round-robin priority, then drives the RAM data, address and enable pins from the winner.
- Routes read data back to the requester that issued the read.
- Sits between the client blocks and the RAM instance; it is the only driver of the RAM pins.

Parameters:
- ADDR_W, 6, RAM address width (depth 2**ADDR_W).
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  access request from R0 / R1; level, held until granted.
- we0 / we1  in  1  1 = write, 0 = read; valid with req.
- addr0 / addr1  in  ADDR_W  access address.
- wdata0 / wdata1  in  DATA_W  write data.
- gnt0 / gnt1  out  1  combinational grant in the request cycle; the access is performed at the next rising edge.
- rvalid0 / rvalid1  out  1  one-cycle pulse; rdata is valid this cycle.
- rdata0 / rdata1  out  DATA_W  registered read data per requester.
- ram_data  out  DATA_W  to RAM data.
- ram_wr_addr  out  ADDR_W  to RAM wr_addr.
- ram_rd_addr  out  ADDR_W  to RAM rd_addr.
- ram_wr_en  out  1  to RAM wr_en.
- ram_q  in  DATA_W  from RAM q.

Behaviour:
- Reset (async, rst_n=0):
  - last_gnt=1, so R0 has first priority.
  - rvalid0/1=0, rdata0/1=0, pending-read register cleared.
  - With no request, RAM pins idle: ram_wr_en=0, addresses 0, data 0.
- Arbitration (combinational, each cycle):
  - Only one req high: that requester is granted.
  - Both high: the requester not equal to last_gnt wins.
  - Neither high: no grant, ram_wr_en=0.
  - gnt0 and gnt1 are never both 1.
- last_gnt updates to the winner at the rising edge, only when a grant occurred; idle cycles leave it unchanged.
- Winner muxing:
  - ram_wr_addr = ram_rd_addr = winner addr.
  - ram_data = winner wdata.
  - ram_wr_en = winner we.
- Write: the RAM stores the data at the edge that ends the grant cycle. No response pulse is returned.
- Read latency: ram_q is sampled one cycle after the grant cycle (the RAM presents q for rd_addr after the edge).
  - At the following edge, rdataN <= ram_q and rvalidN <= 1 for the issuing requester, for exactly one cycle.
  - rdata holds its value until the next read for that requester.
- Pending-read register (valid bit + requester id) carries the read from the grant cycle to the capture cycle.
- Back-to-back reads from alternating requesters are supported, one per cycle. The pipeline never stalls.
- A read and a write to the same address in consecutive cycles return the data as it was before the write, or after it, according to the order in which they were granted.
- An ungranted requester keeps req asserted. Its inputs must stay stable until gnt is seen.
- Reset mid-operation: any in-flight read is dropped (no rvalid after reset release). Priority returns to R0.

Optional Feature:
- Macro: RAM_ARB_LOCK_EN.
- Defined:
  - Adds inputs lock0/lock1 (1 bit each).
  - When the current winner holds lockN=1 together with reqN=1, it keeps the grant on every following cycle, regardless of the other requester (burst ownership).
  - The lock ends in the first cycle where lockN=0 or reqN=0. Normal round-robin then resumes with last_gnt = the locking requester.
  - Lock is ignored unless that requester is the current winner.
- Not defined: lock ports are absent; pure round-robin.

Decomposition:
- Package ram_arb_pkg holds:
  - ADDR_W and DATA_W defaults.
  - NUM_REQ=2.
  - Requester-id type (1 bit) and constants REQ0=0, REQ1=1.
- Sub-module rr_arb2 contains the 2-way round-robin pointer, grant logic and the lock hold when RAM_ARB_LOCK_EN is defined.
- The top level contains the pin mux and the read-return pipeline.

Test Plan:
- Write then read, R0 only:
  - Stimulus: R0 writes 55@0, 100@1, 200@2, then reads 0, 1, 2 on consecutive cycles.
  - Response: gnt0 in every request cycle; rvalid0 pulses on 3 consecutive cycles with rdata0 = 55, 100, 200, each 2 edges after its grant.
- Contention:
  - Stimulus: req0 and req1 held for 4 cycles from reset.
  - Response: grants go R0, R1, R0, R1; never both high.
- Read routing:
  - Stimulus: R0 reads addr 1 and R1 reads addr 2 in adjacent cycles (RAM preloaded with 100, 200).
  - Response: rvalid0 with rdata0=100, then rvalid1 with rdata1=200 one cycle later; the other rvalid stays 0.
- Idle keeps priority:
  - Stimulus: R1 is granted alone, 3 idle cycles follow, then both request.
  - Response: R0 wins.
- Reset mid-read:
  - Stimulus: rst_n pulled low in the cycle after a read grant.
  - Response: no rvalid after release; rdata0/1=0; the first contested grant goes to R0.
- With RAM_ARB_LOCK_EN defined:
  - Stimulus: R1 holds lock1 for 3 cycles while req0 is high.
  - Response: gnt1 on all 3 cycles; gnt0 in the cycle after lock1 falls.
